// File: rtl/fir_ffa3_prog_if.sv
// Streaming and coefficient-programming bus of the 3-parallel fast FIR.
// The master drives blocks and taps; the slave (the filter) returns results.
interface fir_ffa3_prog_if #(
  parameter int unsigned DATA_IN_WIDTH  = 16,
  parameter int unsigned TAP_WIDTH      = 32,
  parameter int unsigned PHASE_TAPS     = 34,
  parameter int unsigned DATA_OUT_WIDTH = 64
);
  localparam int unsigned ADDR_WIDTH = $clog2(3 * PHASE_TAPS);

  logic                             in_valid;
  logic                             in_ready;
  logic signed [DATA_IN_WIDTH-1:0]  data_in_0;
  logic signed [DATA_IN_WIDTH-1:0]  data_in_1;
  logic signed [DATA_IN_WIDTH-1:0]  data_in_2;
  logic                             out_valid;
  logic signed [DATA_OUT_WIDTH-1:0] data_out_0;
  logic signed [DATA_OUT_WIDTH-1:0] data_out_1;
  logic signed [DATA_OUT_WIDTH-1:0] data_out_2;
  logic                             coef_we;
  logic [ADDR_WIDTH-1:0]            coef_addr;
  logic signed [TAP_WIDTH-1:0]      coef_data;
  logic                             coef_commit;

  modport master (
    output in_valid, data_in_0, data_in_1, data_in_2,
    output coef_we, coef_addr, coef_data, coef_commit,
    input  in_ready, out_valid, data_out_0, data_out_1, data_out_2
  );

  modport slave (
    input  in_valid, data_in_0, data_in_1, data_in_2,
    input  coef_we, coef_addr, coef_data, coef_commit,
    output in_ready, out_valid, data_out_0, data_out_1, data_out_2
  );
endinterface

// File: rtl/fir_ffa3_prog.sv
// Programmable 3-parallel fast FIR (FFA): six PHASE_TAPS subfilters, shadow/active
// tap banks with commit, two-edge fixed latency, full-precision accumulation.
module fir_ffa3_prog #(
  parameter int unsigned DATA_IN_WIDTH  = 16,
  parameter int unsigned TAP_WIDTH      = 32,
  parameter int unsigned PHASE_TAPS     = 34,
  parameter int unsigned DATA_OUT_WIDTH = 64
) (
  input  logic          clk,
  input  logic          reset_n,
  fir_ffa3_prog_if.slave bus
);
  localparam int unsigned N_TAPS     = 3 * PHASE_TAPS;
  localparam int unsigned ADDR_WIDTH = $clog2(N_TAPS);
  localparam int unsigned N_SUB      = 6;
  localparam int unsigned XW         = DATA_IN_WIDTH + 2;
  localparam int unsigned HW         = TAP_WIDTH + 2;
  localparam int unsigned PW         = XW + HW;
  localparam int unsigned ACC_W      = PW + $clog2(PHASE_TAPS) + 4;
  localparam int unsigned SW         = (ACC_W > DATA_OUT_WIDTH) ? ACC_W : DATA_OUT_WIDTH;

  if (DATA_OUT_WIDTH < DATA_IN_WIDTH + TAP_WIDTH + 4) begin : g_width_check
    $error("fir_ffa3_prog: DATA_OUT_WIDTH must be at least DATA_IN_WIDTH+TAP_WIDTH+4");
  end

  logic signed [TAP_WIDTH-1:0]      shadow_q   [N_TAPS];
  logic signed [TAP_WIDTH-1:0]      shadow_nxt [N_TAPS];
  logic signed [TAP_WIDTH-1:0]      active_q   [N_TAPS];
  logic signed [HW-1:0]             sub_h      [N_SUB][PHASE_TAPS];
  logic signed [XW-1:0]             x0, x1, x2;
  logic signed [XW-1:0]             sub_x      [N_SUB];
  logic signed [XW-1:0]             dl_q       [N_SUB][PHASE_TAPS];
  logic signed [SW-1:0]             acc        [N_SUB];
  logic signed [SW-1:0]             y0_c, y1_c, y2_c, z0_c, z1_c;
  logic signed [SW-1:0]             z0_q, z1_q;
  logic signed [DATA_OUT_WIDTH-1:0] y0_q, y1_q, y2_q;
  logic                             rdy_q;
  logic                             v1_q;
  logic                             out_valid_q;
  logic                             accept;

  assign bus.in_ready   = rdy_q & ~bus.coef_commit;
  assign accept         = bus.in_valid & bus.in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.data_out_0 = y0_q;
  assign bus.data_out_1 = y1_q;
  assign bus.data_out_2 = y2_q;

  // Shadow bank with this cycle's write folded in, so a same-cycle commit sees it.
  always_comb begin
    for (int j = 0; j < N_TAPS; j++) begin
      shadow_nxt[j] = shadow_q[j];
      if (bus.coef_we && (bus.coef_addr == ADDR_WIDTH'(j))) begin
        shadow_nxt[j] = bus.coef_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdy_q <= 1'b0;
      for (int j = 0; j < N_TAPS; j++) begin
        shadow_q[j] <= '0;
        active_q[j] <= '0;
      end
    end else begin
      rdy_q <= 1'b1;
      for (int j = 0; j < N_TAPS; j++) begin
        shadow_q[j] <= shadow_nxt[j];
        if (bus.coef_commit) begin
          active_q[j] <= shadow_nxt[j];
        end
      end
    end
  end

  // Polyphase taps Hp[i] = h[3i+p] and the three sum-subfilters.
  always_comb begin
    for (int i = 0; i < PHASE_TAPS; i++) begin
      sub_h[0][i] = HW'(active_q[3*i]);
      sub_h[1][i] = HW'(active_q[3*i+1]);
      sub_h[2][i] = HW'(active_q[3*i+2]);
      sub_h[3][i] = HW'(active_q[3*i]) + HW'(active_q[3*i+1]);
      sub_h[4][i] = HW'(active_q[3*i+1]) + HW'(active_q[3*i+2]);
      sub_h[5][i] = HW'(active_q[3*i]) + HW'(active_q[3*i+1]) + HW'(active_q[3*i+2]);
    end
  end

  always_comb begin
    x0       = XW'(bus.data_in_0);
    x1       = XW'(bus.data_in_1);
    x2       = XW'(bus.data_in_2);
    sub_x[0] = x0;
    sub_x[1] = x1;
    sub_x[2] = x2;
    sub_x[3] = x0 + x1;
    sub_x[4] = x1 + x2;
    sub_x[5] = x0 + x1 + x2;
  end

  // Subfilter delay lines move only on accepted blocks; commit empties them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < N_SUB; s++) begin
        for (int i = 0; i < PHASE_TAPS; i++) begin
          dl_q[s][i] <= '0;
        end
      end
    end else if (bus.coef_commit) begin
      for (int s = 0; s < N_SUB; s++) begin
        for (int i = 0; i < PHASE_TAPS; i++) begin
          dl_q[s][i] <= '0;
        end
      end
    end else if (accept) begin
      for (int s = 0; s < N_SUB; s++) begin
        dl_q[s][0] <= sub_x[s];
        for (int i = 1; i < PHASE_TAPS; i++) begin
          dl_q[s][i] <= dl_q[s][i-1];
        end
      end
    end
  end

  always_comb begin
    for (int s = 0; s < N_SUB; s++) begin
      acc[s] = '0;
      for (int i = 0; i < PHASE_TAPS; i++) begin
        acc[s] = acc[s] + SW'(PW'(sub_h[s][i]) * PW'(dl_q[s][i]));
      end
    end
  end

  // FFA post-additions; z0/z1 carry the previous block's cross terms.
  always_comb begin
    y0_c = acc[0] + z0_q;
    y1_c = acc[3] - acc[0] - acc[1] + z1_q;
    y2_c = acc[5] - acc[3] - acc[4] + acc[1] + acc[1];
    z0_c = acc[4] - acc[1] - acc[2];
    z1_c = acc[2];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_q        <= 1'b0;
      out_valid_q <= 1'b0;
      z0_q        <= '0;
      z1_q        <= '0;
      y0_q        <= '0;
      y1_q        <= '0;
      y2_q        <= '0;
    end else if (bus.coef_commit) begin
      v1_q        <= 1'b0;
      out_valid_q <= 1'b0;
      z0_q        <= '0;
      z1_q        <= '0;
    end else begin
      v1_q        <= accept;
      out_valid_q <= v1_q;
      if (v1_q) begin
        y0_q <= DATA_OUT_WIDTH'(y0_c);
        y1_q <= DATA_OUT_WIDTH'(y1_c);
        y2_q <= DATA_OUT_WIDTH'(y2_c);
        z0_q <= z0_c;
        z1_q <= z1_c;
      end
    end
  end
endmodule

// File: tb/tb_fir_ffa3_prog.sv
// Directed bench for fir_ffa3_prog: direct-convolution model feeds a scoreboard
// queue at drive time; a monitor pops and compares when out_valid appears.
module tb_fir_ffa3_prog;
  localparam int unsigned DI  = 16;
  localparam int unsigned TW  = 32;
  localparam int unsigned PT  = 34;
  localparam int unsigned DOW = 64;
  localparam int unsigned NT  = 3 * PT;
  localparam int unsigned AW  = $clog2(NT);

  typedef struct {
    logic signed [DOW-1:0] y0;
    logic signed [DOW-1:0] y1;
    logic signed [DOW-1:0] y2;
  } trip_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;

  fir_ffa3_prog_if #(.DATA_IN_WIDTH(DI), .TAP_WIDTH(TW), .PHASE_TAPS(PT),
                     .DATA_OUT_WIDTH(DOW)) bus ();

  fir_ffa3_prog #(.DATA_IN_WIDTH(DI), .TAP_WIDTH(TW), .PHASE_TAPS(PT),
                  .DATA_OUT_WIDTH(DOW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int     checks  = 0;
  int     errors  = 0;
  int     out_cnt = 0;
  int     acc_cnt = 0;
  trip_t  exp_q[$];
  trip_t  last_out;
  trip_t  mon_e;
  longint sh_m  [NT];
  longint act_m [NT];
  int     hist[$];

  task automatic chk(input string tag, input logic [DOW-1:0] obs, input logic [DOW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic longint y_at(input int n);
    longint s = 0;
    for (int j = 0; j < NT; j++) begin
      if (n - j >= 0) s += act_m[j] * longint'(hist[n-j]);
    end
    return s;
  endfunction

  function automatic int rnd_x();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  // One cycle: drive at the falling edge, update the model, return at the next falling edge.
  task automatic step(input bit v, input int a, input int b, input int c,
                      input bit we = 1'b0, input int addr = 0, input longint data = 0,
                      input bit commit = 1'b0);
    logic signed [TW-1:0] d;
    trip_t t;
    int n0;
    bus.in_valid    = v;
    bus.data_in_0   = DI'(a);
    bus.data_in_1   = DI'(b);
    bus.data_in_2   = DI'(c);
    bus.coef_we     = we;
    bus.coef_addr   = AW'(addr);
    bus.coef_data   = TW'(data);
    bus.coef_commit = commit;
    #1;
    chk("in_ready", 64'(bus.in_ready), 64'(!commit));
    d = TW'(data);
    if (we && addr < NT) sh_m[addr] = longint'(d);
    if (commit) begin
      act_m = sh_m;
      hist.delete();
      exp_q.delete();
    end else if (v) begin
      hist.push_back(a);
      hist.push_back(b);
      hist.push_back(c);
      n0 = hist.size() - 3;
      t.y0 = y_at(n0);
      t.y1 = y_at(n0 + 1);
      t.y2 = y_at(n0 + 2);
      exp_q.push_back(t);
      acc_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0);
  endtask

  task automatic load_taps_const(input int nz, input longint val);
    for (int j = 0; j < NT; j++) step(1'b0, 0, 0, 0, 1'b1, j, (j < nz) ? val : 0);
  endtask

  // Asynchronous reset at an arbitrary point inside the cycle.
  task automatic do_reset(input int dly);
    bus.in_valid    = 1'b0;
    bus.coef_we     = 1'b0;
    bus.coef_commit = 1'b0;
    #(dly);
    reset_n = 1'b0;
    exp_q.delete();
    hist.delete();
    for (int j = 0; j < NT; j++) begin
      sh_m[j]  = 0;
      act_m[j] = 0;
    end
    last_out = '{0, 0, 0};
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_data_out_0", bus.data_out_0, 64'(0));
    chk("rst_data_out_1", bus.data_out_1, 64'(0));
    chk("rst_data_out_2", bus.data_out_2, 64'(0));
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("release_in_ready_low", 64'(bus.in_ready), 64'(0));
    @(negedge clk);
    chk("release_in_ready_high", 64'(bus.in_ready), 64'(1));
  endtask

  always @(posedge clk) begin
    #1;
    if (!reset_n) begin
      chk("mon_rst_out_valid", 64'(bus.out_valid), 64'(0));
      chk("mon_rst_data_out_0", bus.data_out_0, 64'(0));
    end else if (bus.out_valid) begin
      out_cnt++;
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL stale_out_valid observed=1 expected=0");
      end
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("y0", bus.data_out_0, mon_e.y0);
        chk("y1", bus.data_out_1, mon_e.y1);
        chk("y2", bus.data_out_2, mon_e.y2);
        last_out = mon_e;
      end
    end else begin
      chk("hold_0", bus.data_out_0, last_out.y0);
      chk("hold_1", bus.data_out_1, last_out.y1);
      chk("hold_2", bus.data_out_2, last_out.y2);
    end
  end

  initial begin
    int oc0, ac0;
    bus.in_valid = 1'b0; bus.data_in_0 = '0; bus.data_in_1 = '0; bus.data_in_2 = '0;
    bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_data = '0; bus.coef_commit = 1'b0;
    do_reset(1);

    // Zero taps after reset: any input yields zero.
    for (int k = 0; k < 4; k++) step(1'b1, rnd_x(), rnd_x(), rnd_x());
    idle(3);

    // Impulse through h[j] = j+1; an out-of-range write must be ignored.
    for (int j = 0; j < NT; j++) step(1'b0, 0, 0, 0, 1'b1, j, j + 1);
    step(1'b0, 0, 0, 0, 1'b1, 127, 32'h7fff_ffff);
    step(1'b0, 0, 0, 0, 1'b0, 0, 0, 1'b1);
    step(1'b1, 1, 0, 0);
    for (int k = 0; k < 36; k++) step(1'b1, 0, 0, 0);
    idle(3);

    // Width: unit tap with full-scale negative input, then three -2^31 taps.
    load_taps_const(1, 1);
    step(1'b0, 0, 0, 0, 1'b0, 0, 0, 1'b1);
    for (int k = 0; k < 8; k++) step(1'b1, -32768, -32768, -32768);
    load_taps_const(3, -64'sd2147483648);
    step(1'b0, 0, 0, 0, 1'b0, 0, 0, 1'b1);
    for (int k = 0; k < 40; k++) step(1'b1, -32768, -32768, -32768);
    idle(3);

    // Bubbles with random taps.
    for (int j = 0; j < NT; j++) step(1'b0, 0, 0, 0, 1'b1, j, longint'($urandom));
    step(1'b0, 0, 0, 0, 1'b0, 0, 0, 1'b1);
    oc0 = out_cnt;
    ac0 = acc_cnt;
    for (int k = 0; k < 80; k++) step(($urandom_range(0, 9) < 6), rnd_x(), rnd_x(), rnd_x());
    idle(4);
    checks++;
    assert ((out_cnt - oc0) == (acc_cnt - ac0)) else begin
      errors++;
      $error("FAIL out_valid_count observed=%0d expected=%0d", out_cnt - oc0, acc_cnt - ac0);
    end

    // Shadow writes while streaming leave the output alone; then commit mid-stream.
    for (int k = 0; k < 20; k++)
      step(1'b1, rnd_x(), rnd_x(), rnd_x(), 1'b1, int'($urandom_range(0, NT - 1)), longint'($urandom));
    step(1'b1, rnd_x(), rnd_x(), rnd_x(), 1'b0, 0, 0, 1'b1);
    for (int k = 0; k < 40; k++) step(1'b1, rnd_x(), rnd_x(), rnd_x());
    idle(3);

    // Same-cycle write and commit: only h[5] = 7.
    load_taps_const(0, 0);
    step(1'b0, 0, 0, 0, 1'b1, 5, 7, 1'b1);
    step(1'b1, 1, 0, 0);
    for (int k = 0; k < 3; k++) step(1'b1, 0, 0, 0);
    idle(3);

    // Reset in the middle of a stream abandons in-flight blocks.
    for (int k = 0; k < 5; k++) step(1'b1, rnd_x(), rnd_x(), rnd_x());
    do_reset(int'($urandom_range(1, 4)));
    for (int k = 0; k < 3; k++) step(1'b1, rnd_x(), rnd_x(), rnd_x());
    idle(4);

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL drained_queue observed=%0d expected=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fir_ffa3_prog.md
FIR_FFA3_PROG -- requirements
Module: fir_ffa3_prog

Interface
REQ-001 SHALL have parameter DATA_IN_WIDTH, default 16, signed input sample width.
REQ-002 SHALL have parameter TAP_WIDTH, default 32, signed coefficient width.
REQ-003 SHALL have parameter PHASE_TAPS, default 34, taps per polyphase branch; total taps N = 3*PHASE_TAPS.
REQ-004 SHALL have parameter DATA_OUT_WIDTH, default 64, signed output width.
REQ-005 SHALL have clk  input  1  clock; reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have in_valid  input  1  block of three samples present.
REQ-007 SHALL have in_ready  output  1  block accepted when in_valid && in_ready at rising clk.
REQ-008 SHALL have data_in_0/1/2  input  DATA_IN_WIDTH each  samples x(3k), x(3k+1), x(3k+2).
REQ-009 SHALL have out_valid  output  1  output block present, one cycle per block, no backpressure.
REQ-010 SHALL have data_out_0/1/2  output  DATA_OUT_WIDTH each  y(3k), y(3k+1), y(3k+2).
REQ-011 SHALL have coef_we  input  1; coef_addr  input  clog2(N); coef_data  input  TAP_WIDTH: shadow tap write h[coef_addr].
REQ-012 SHALL have coef_commit  input  1  one-cycle pulse copying shadow taps into active taps.

Function
REQ-013 SHALL compute y(n) = sum over j=0..N-1 of h[j]*x(n-j) using active taps, with x before the first accepted block after reset/commit taken as 0.
REQ-014 SHALL use 3-parallel fast FIR structure: six PHASE_TAPS-long subfilters H0, H1, H2, H0+H1, H1+H2, H0+H1+H2, where Hp[i] = h[3i+p].
REQ-015 SHALL derive subfilter sum-taps internally from active taps; widen them to TAP_WIDTH+2.
REQ-016 SHALL widen input pre-adds (x0+x1, x1+x2, x0+x1+x2) to DATA_IN_WIDTH+2 bits, with no truncation.
REQ-017 SHALL keep products and accumulations at full precision; the final result wraps (two's complement) to DATA_OUT_WIDTH.
REQ-018 SHALL advance subfilter delay lines and the inter-block z^-1 registers only on accepted blocks; idle cycles hold all state.
REQ-019 SHALL have fixed latency: block accepted at edge t; data_out valid with out_valid=1 after edge t+1 (2 edges); out_valid=0 otherwise.
REQ-020 SHALL hold data_out at the last valid value while out_valid=0.
REQ-021 SHALL write shadow[coef_addr] <= coef_data on coef_we; addresses >= N are ignored; active taps remain unaffected.
REQ-022 On coef_commit, SHALL set active <= shadow at that edge and clear all delay lines, z^-1 registers and the valid pipeline; in_ready=0 during the commit cycle, and in_valid in that cycle is not accepted.
REQ-023 When coef_we and coef_commit occur in the same cycle, SHALL include that write in the committed taps.
REQ-024 SHALL keep in_ready=1 in all non-commit cycles.
REQ-025 Outputs of blocks in flight at commit SHALL be discarded: out_valid=0 for those.
REQ-026 Elaboration SHALL fail if DATA_OUT_WIDTH < DATA_IN_WIDTH+TAP_WIDTH+4.

Reset
REQ-027 reset_n low SHALL immediately clear data_out_0/1/2 to 0, out_valid to 0, and all delay lines, shadow taps and active taps to 0.
REQ-028 SHALL drive in_ready=0 during reset and in_ready=1 from the first edge after release.
REQ-029 Reset asserted mid-stream SHALL abandon in-flight blocks with no out_valid pulse.

Verification
REQ-030 Reset: assert reset_n=0 at random time -> all outputs 0, out_valid 0; after release, any input gives y=0 (taps zero).
REQ-031 Impulse: h[j]=j+1 for j=0..101, commit, blocks (1,0,0) then zeros -> block k gives y=(3k+1, 3k+2, 3k+3) for k=0..33, then 0.
REQ-032 Width: h[0]=1 only, all inputs -32768 -> every output -32768; h[0]=h[1]=h[2]=-2^31, inputs -32768 -> steady y=3*2^46.
REQ-033 Bubbles: random in_valid gaps, random taps -> output sequence equals golden convolution; out_valid count equals accepted count.
REQ-034 Coef update: shadow writes without commit -> output unchanged; commit mid-stream -> in_ready=0 one cycle, no stale out_valid, subsequent outputs match fresh filter with new taps.
REQ-035 Same-cycle coef_we+coef_commit to h[5]=7 with others 0 -> impulse response 7 at y(5) only.
